// File: rtl/pc_gen_pkg.sv
// Shared fetch-side constants and types.
// Defaults for the PC generator and its next-PC source encoding.
package pc_gen_pkg;

  localparam int unsigned PC_INCR        = 4;
  localparam int unsigned B_OFFSET_MSB   = 23;
  localparam int unsigned B_OFFSET_LSB   = 0;
  localparam int unsigned B_OFFSET_SHIFT = 2;
  localparam int unsigned RESET_VECTOR   = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_REDIR,
    SEL_HOLD,
    SEL_POP,
    SEL_MISS,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

  // Priority order of next-PC sources.
  function automatic pc_sel_e pc_select(
    input logic reset,
    input logic redirect,
    input logic stall,
    input logic ret,
    input logic ras_empty,
    input logic branch
  );
    if (reset)         return SEL_RESET;
    else if (redirect) return SEL_REDIR;
    else if (stall)    return SEL_HOLD;
    else if (ret)      return ras_empty ? SEL_MISS : SEL_POP;
    else if (branch)   return SEL_BRANCH;
    else               return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_gen_return_stack.sv
// Circular return-address stack.
// A push when full overwrites the oldest entry.
module return_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] cnt_q;

  // ptr_q is the next write slot; the top sits one below it.
  always_comb begin
    ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;
  end

  // Entry storage; a push with a pop replaces the top in place.
  always_ff @(posedge clk) begin
    if (!clear && push) begin
      if (pop) mem_q[ptr_dec] <= din;
      else     mem_q[ptr_q]   <= din;
    end
  end

  // Pointer and saturating occupancy count.
  always_ff @(posedge clk) begin
    if (clear) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push && pop) begin
      ptr_q <= ptr_q;
      cnt_q <= cnt_q;
    end else if (push) begin
      ptr_q <= ptr_inc;
      if (cnt_q != CNT_W'(DEPTH)) cnt_q <= cnt_q + 1'b1;
    end else if (pop && cnt_q != '0) begin
      ptr_q <= ptr_dec;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign top   = mem_q[ptr_dec];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/sign_extend.sv
// Shared sign extender.
// Replicates the input MSB up to the output width.
module sign_extend #(
  parameter int unsigned IN  = 24,
  parameter int unsigned OUT = 32
) (
  input  logic [IN-1:0]  din,
  output logic [OUT-1:0] dout
);

  assign dout = {{(OUT-IN){din[IN-1]}}, din};

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator.
// Sequential, branch, call/return and redirect targets.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned OFFSET_W     =
    pc_gen_pkg::B_OFFSET_MSB - pc_gen_pkg::B_OFFSET_LSB + 1,
  parameter int unsigned OFFSET_SHIFT = pc_gen_pkg::B_OFFSET_SHIFT,
  parameter int unsigned PC_INCR      = pc_gen_pkg::PC_INCR,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(pc_gen_pkg::RESET_VECTOR),
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              link,
  input  logic              ret,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] link_addr,
  output logic              ras_empty,
  output logic              ret_miss
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] link_q;
  logic              miss_q;
  logic              miss_d;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_emp;
  logic              push;
  logic              pop;
  pc_sel_e           sel;

  generate
    if (OFFSET_W < 32) begin : g_inst_hi
      logic unused_inst_hi;
      assign unused_inst_hi = ^inst[31:OFFSET_W];
    end
  endgenerate

  sign_extend #(
    .IN  (OFFSET_W),
    .OUT (ADDR_W)
  ) u_sext (
    .din  (inst[OFFSET_W-1:0]),
    .dout (off_ext)
  );

  return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .clear (reset),
    .push  (push),
    .pop   (pop),
    .din   (seq),
    .top   (ras_top),
    .count (ras_cnt),
    .empty (ras_emp)
  );

  // Candidate targets and the next-PC select.
  always_comb begin
    seq    = pc_q + ADDR_W'(PC_INCR);
    br_tgt = seq + (off_ext << OFFSET_SHIFT);
    sel    = pc_select(reset, redirect, stall,
                       ret, ras_emp, branch);
    push   = (sel == SEL_BRANCH) && link;
    pop    = (sel == SEL_POP);
    miss_d = (sel == SEL_MISS);
    pc_d   = seq;
    unique case (sel)
      SEL_RESET:  pc_d = RESET_PC;
      SEL_REDIR:  pc_d = redirect_pc;
      SEL_HOLD:   pc_d = pc_q;
      SEL_POP:    pc_d = ras_top;
      SEL_MISS:   pc_d = seq;
      SEL_BRANCH: pc_d = br_tgt;
      SEL_SEQ:    pc_d = seq;
      default:    pc_d = seq;
    endcase
  end

  // PC, link address and return-miss registers.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    miss_q <= miss_d;
    if (reset)     link_q <= '0;
    else if (push) link_q <= seq;
  end

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign link_addr = link_q;
  assign ras_empty = (ras_cnt == '0);
  assign ret_miss  = miss_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen.
// Expected PCs are queued at drive time and popped after the edge.
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic        link;
  logic        ret;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] link_addr;
  logic        ras_empty;
  logic        ret_miss;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  pc_gen dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .branch      (branch),
    .link        (link),
    .ret         (ret),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .pc          (pc),
    .pc_next     (pc_next),
    .link_addr   (link_addr),
    .ras_empty   (ras_empty),
    .ret_miss    (ret_miss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] a);
    redirect    = 1'b1;
    redirect_pc = a;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h0);
      #1;
      checks++;
      if (pc_next !== exp_q[$]) begin
        failures++;
        $display("FAIL reset_pc_next got=%h exp=%h", pc_next, exp_q[$]);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e) begin
        failures++;
        $display("FAIL reset_pc got=%h exp=%h", pc, e);
      end
    end
    checks++;
    if (link_addr !== 32'h0 || ras_empty !== 1'b1 || ret_miss !== 1'b0) begin
      failures++;
      $display("FAIL reset_state link=%h empty=%b miss=%b exp 0/1/0",
               link_addr, ras_empty, ret_miss);
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(32'(i * 4));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || link_addr !== 32'h0 || ras_empty !== 1'b1) begin
        failures++;
        $display("FAIL free_run pc=%h exp=%h link=%h empty=%b",
                 pc, e, link_addr, ras_empty);
      end
    end
  endtask

  task automatic test_backward_branch();
    logic [31:0] e;
    go_to(32'h100);
    branch = 1'b1;
    inst   = 32'h00FF_FFFE;
    exp_q.push_back(32'hFC);
    #1;
    checks++;
    if (pc_next !== exp_q[$]) begin
      failures++;
      $display("FAIL bwd_pc_next got=%h exp=%h", pc_next, exp_q[$]);
    end
    tick();
    branch = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (pc !== e) begin
      failures++;
      $display("FAIL bwd_branch got=%h exp=%h", pc, e);
    end
  endtask

  task automatic test_call_return();
    logic [31:0] e;
    go_to(32'h200);
    branch = 1'b1;
    link   = 1'b1;
    inst   = 32'h0000_0010;
    exp_q.push_back(32'h244);
    tick();
    branch = 1'b0;
    link   = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (pc !== e || link_addr !== 32'h204 || ras_empty !== 1'b0) begin
      failures++;
      $display("FAIL call pc=%h exp=%h link=%h exp=204 empty=%b exp=0",
               pc, e, link_addr, ras_empty);
    end
    ret = 1'b1;
    exp_q.push_back(32'h204);
    tick();
    ret = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (pc !== e || ras_empty !== 1'b1 || ret_miss !== 1'b0) begin
      failures++;
      $display("FAIL return pc=%h exp=%h empty=%b miss=%b exp 1/0",
               pc, e, ras_empty, ret_miss);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] e;
    go_to(32'h0);
    branch = 1'b1;
    link   = 1'b1;
    inst   = 32'h0000_03FF;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'((i + 1) * 32'h1000));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || link_addr !== 32'(i * 32'h1000 + 4)) begin
        failures++;
        $display("FAIL nest_call%0d pc=%h exp=%h link=%h", i, pc, e, link_addr);
      end
    end
    branch = 1'b0;
    link   = 1'b0;
    ret    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h4004 - 32'(i * 32'h1000));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || ret_miss !== 1'b0) begin
        failures++;
        $display("FAIL nest_ret%0d pc=%h exp=%h miss=%b", i, pc, e, ret_miss);
      end
    end
    checks++;
    if (ras_empty !== 1'b1) begin
      failures++;
      $display("FAIL ras_drained empty=%b exp=1", ras_empty);
    end
    exp_q.push_back(32'h1008);
    tick();
    ret = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (pc !== e || ret_miss !== 1'b1) begin
      failures++;
      $display("FAIL ret_empty pc=%h exp=%h miss=%b exp=1", pc, e, ret_miss);
    end
    exp_q.push_back(32'h100C);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc !== e || ret_miss !== 1'b0) begin
      failures++;
      $display("FAIL miss_pulse pc=%h exp=%h miss=%b exp=0", pc, e, ret_miss);
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] e;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h100C);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e) begin
        failures++;
        $display("FAIL stall%0d pc=%h exp=%h", i, pc, e);
      end
    end
    redirect    = 1'b1;
    redirect_pc = 32'h8000;
    exp_q.push_back(32'h8000);
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (pc !== e) begin
      failures++;
      $display("FAIL stall_redirect pc=%h exp=%h", pc, e);
    end
    branch = 1'b1;
    link   = 1'b1;
    inst   = 32'h0000_0040;
    exp_q.push_back(32'h8104);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc !== e || link_addr !== 32'h8004) begin
      failures++;
      $display("FAIL call2 pc=%h exp=%h link=%h", pc, e, link_addr);
    end
    ret = 1'b1;
    exp_q.push_back(32'h8004);
    tick();
    ret    = 1'b0;
    branch = 1'b0;
    link   = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (pc !== e || ras_empty !== 1'b1 || link_addr !== 32'h8004) begin
      failures++;
      $display("FAIL ret_over_branch pc=%h exp=%h empty=%b link=%h",
               pc, e, ras_empty, link_addr);
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] e;
    branch = 1'b1;
    link   = 1'b1;
    inst   = 32'h0;
    tick();
    branch = 1'b0;
    link   = 1'b0;
    reset  = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    reset = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (pc !== e || ras_empty !== 1'b1 || link_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_flush pc=%h exp=%h empty=%b link=%h",
               pc, e, ras_empty, link_addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    go_to(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc !== e) begin
      failures++;
      $display("FAIL wrap_seq pc=%h exp=%h", pc, e);
    end
    go_to(32'hFFFF_FFFC);
    branch = 1'b1;
    inst   = 32'h0000_0001;
    exp_q.push_back(32'h4);
    tick();
    branch = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (pc !== e) begin
      failures++;
      $display("FAIL wrap_branch pc=%h exp=%h", pc, e);
    end
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    branch      = 1'b0;
    link        = 1'b0;
    ret         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst        = 32'h0;
    #1;
    test_reset();
    test_backward_branch();
    test_call_return();
    test_ras_overflow();
    test_stall_redirect();
    test_reset_flush();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
